tone_monitor: RTL

//  Synthesizable per-channel tone checker for the equalizer output path. It is the parametrised successor
//  of the bench-only zero-crossing/amplitude checks. On every sample strobe it watches NUM_CH signed streams
//  (e.g. codec aout_lft/aout_rht), detects neg->pos zero crossings, counts samples per period and tracks peak

---
 rtl/tone_monitor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/tone_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tone_monitor                                              |
// | Purpose  : per-channel zero-crossing period/peak checker that counts |
// |            periods outside programmable frequency/amplitude windows. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tone_monitor #(
    parameter int NUM_CH       = 2,
    parameter int DATA_W       = 16,
    parameter int CNT_W        = 8,
    parameter int ERR_W        = 16,
    parameter int SETTLE_XINGS = 10,
    parameter int HYST         = 0,
    parameter int TIMEOUT      = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     smpl_vld,
    input  logic [NUM_CH*DATA_W-1:0] smpl,
    input  logic [15:0]              test_len,
    input  logic [CNT_W-1:0]         min_cnt,
    input  logic [CNT_W-1:0]         max_cnt,
    input  logic [DATA_W-1:0]        min_ampl,
    input  logic [DATA_W-1:0]        max_ampl,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [NUM_CH*ERR_W-1:0]  freq_err,
    output logic [NUM_CH*ERR_W-1:0]  ampl_err
);

    localparam int c_TO_W = $clog2(TIMEOUT + 2);
    localparam int c_SX_W = (SETTLE_XINGS < 2) ? 1 : $clog2(SETTLE_XINGS + 1);
    localparam logic [c_TO_W-1:0]        c_TIMEOUT  = c_TO_W'(TIMEOUT);
    localparam logic [c_SX_W-1:0]        c_SETTLE   = c_SX_W'(SETTLE_XINGS);
    localparam logic signed [DATA_W-1:0] c_NEG_HYST = DATA_W'(-HYST);

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_RUN  = 2'd1,
        G_DONE = 2'd2
    } g_state_t;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ARMED = 2'd1,
        CH_MEAS  = 2'd2,
        CH_FIN   = 2'd3
    } ch_state_t;

    g_state_t          r_gstate;
    logic              r_busy;
    logic              r_done;
    logic              w_launch;
    logic [NUM_CH-1:0] w_ch_fin;

    // abort overrides start; start is only honoured outside RUN
    assign w_launch = start && !abort && (r_gstate != G_RUN);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_gstate <= G_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_gstate)
                G_RUN: begin
                    if (&w_ch_fin) begin
                        r_gstate <= G_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        r_gstate <= G_RUN;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign pass = r_done && (freq_err == '0) && (ampl_err == '0);

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            ch_state_t                r_state;
            logic                     r_neg;
            logic                     r_chk;
            logic [CNT_W-1:0]         r_cnt;
            logic signed [DATA_W-1:0] r_peak;
            logic [c_SX_W-1:0]        r_xings;
            logic [c_TO_W-1:0]        r_arm;
            logic [16:0]              r_smp;
            logic [ERR_W-1:0]         r_freq_err;
            logic [ERR_W-1:0]         r_ampl_err;

            logic signed [DATA_W-1:0] w_s;
            logic signed [DATA_W-1:0] w_peak_max;
            logic                     w_below;
            logic                     w_xing;
            logic                     w_freq_bad;
            logic                     w_ampl_bad;
            logic                     w_settled;
            logic                     w_timeout;
            logic                     w_len_done;
            logic [CNT_W-1:0]         w_cnt_inc;
            logic [c_SX_W-1:0]        w_xings_nxt;
            logic [c_TO_W-1:0]        w_arm_nxt;
            logic [16:0]              w_smp_nxt;
            logic [ERR_W-1:0]         w_freq_up;
            logic [ERR_W-1:0]         w_ampl_up;

            assign w_s         = smpl[ch*DATA_W +: DATA_W];
            assign w_below     = (w_s < c_NEG_HYST);
            assign w_xing      = r_neg && !w_s[DATA_W-1];
            // the crossing sample closes its own period: measure with it included
            assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
            assign w_peak_max  = (w_s > r_peak) ? w_s : r_peak;
            assign w_freq_bad  = (w_cnt_inc < min_cnt) || (w_cnt_inc > max_cnt);
            assign w_ampl_bad  = (w_peak_max < $signed(min_ampl)) ||
                                 (w_peak_max > $signed(max_ampl));
            assign w_xings_nxt = r_xings + c_SX_W'(1);
            assign w_settled   = w_xing && (w_xings_nxt == c_SETTLE);
            assign w_arm_nxt   = r_arm + c_TO_W'(1);
            assign w_timeout   = (w_arm_nxt > c_TIMEOUT);
            assign w_smp_nxt   = r_smp + 17'd1;
            assign w_len_done  = (w_smp_nxt >= {1'b0, test_len});
            assign w_freq_up   = (r_freq_err == '1) ? r_freq_err : r_freq_err + ERR_W'(1);
            assign w_ampl_up   = (r_ampl_err == '1) ? r_ampl_err : r_ampl_err + ERR_W'(1);

            assign w_ch_fin[ch]                 = (r_state == CH_FIN);
            assign freq_err[ch*ERR_W +: ERR_W]  = r_freq_err;
            assign ampl_err[ch*ERR_W +: ERR_W]  = r_ampl_err;

            always_ff @(posedge clk) begin
                if (rst || abort || w_launch) begin
                    r_state    <= (rst || abort) ? CH_IDLE : CH_ARMED;
                    r_neg      <= 1'b0;
                    r_chk      <= 1'b0;
                    r_cnt      <= '0;
                    r_peak     <= '0;
                    r_xings    <= '0;
                    r_arm      <= '0;
                    r_smp      <= '0;
                    r_freq_err <= '0;
                    r_ampl_err <= '0;
                end else if (smpl_vld && (r_state != CH_IDLE)) begin
                    r_cnt  <= w_xing ? '0 : w_cnt_inc;
                    r_peak <= w_xing ? '0 : w_peak_max;
                    if (w_xing) begin
                        r_neg <= 1'b0;
                    end else if (w_below) begin
                        r_neg <= 1'b1;
                    end
                    case (r_state)
                        CH_ARMED: begin
                            r_arm <= w_arm_nxt;
                            if (w_xing) begin
                                r_xings <= w_xings_nxt;
                            end
                            // the entering crossing is the first measured sample
                            if (w_settled) begin
                                r_smp <= 17'd1;
                                if (test_len <= 16'd1) begin
                                    r_state    <= CH_FIN;
                                    r_freq_err <= w_freq_up;
                                end else begin
                                    r_state <= CH_MEAS;
                                end
                            end else if (w_timeout) begin
                                r_state    <= CH_FIN;
                                r_freq_err <= w_freq_up;
                            end
                        end
                        CH_MEAS: begin
                            r_smp <= w_smp_nxt;
                            if (w_xing) begin
                                r_chk <= 1'b1;
                                if (w_freq_bad) begin
                                    r_freq_err <= w_freq_up;
                                end
                                if (w_ampl_bad) begin
                                    r_ampl_err <= w_ampl_up;
                                end
                            end
                            if (w_len_done) begin
                                r_state <= CH_FIN;
                                if (!w_xing && !r_chk) begin
                                    r_freq_err <= w_freq_up;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire
